// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) vs multi-cycle unit (B), with anti-starvation stall.
// Ports: clk, rst_n, A/B requests, b_ready, pipe_stall, rf_* write port, rd_* read path. Optional macro: WB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  input  logic [31:0] rd_data1_in,
  input  logic [31:0] rd_data2_in,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2
);

  typedef enum logic {
    RUN,
    STARVE
  } state_e;

  localparam logic [3:0] LAST = 4'(MAX_WAIT - 1);

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  logic        grant_a;
  logic        grant_b;
  logic        win_v;
  logic [4:0]  win_reg;
  logic [31:0] win_data;
  logic        win_wr;

  // STARVE ignores A entirely; A is held upstream by pipe_stall.
  assign b_ready    = rst_n & ((state_q == STARVE) | ~a_valid);
  assign grant_a    = (state_q == RUN) & a_valid;
  assign grant_b    = b_valid & b_ready;
  assign win_v      = grant_a | grant_b;
  assign win_reg    = grant_a ? a_reg : b_reg;
  assign win_data   = grant_a ? a_data : b_data;
  // r0 writes are granted but never reach the port.
  assign win_wr     = win_v & (win_reg != 5'd0);

  assign pipe_stall = (state_q == STARVE);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (a_valid && b_valid) begin
            if (wait_cnt_q == LAST) begin
              state_q    <= STARVE;
              wait_cnt_q <= 4'd0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 4'd1;
            end
          end else begin
            // B idle or B granted: the loss streak is broken.
            wait_cnt_q <= 4'd0;
          end
        end
        STARVE: begin
          state_q    <= RUN;
          wait_cnt_q <= 4'd0;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 4'd0;
        end
      endcase

      rf_we_q <= win_wr;
      if (win_wr) begin
        rf_waddr_q <= win_reg;
        rf_wdata_q <= win_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write so reads see it one cycle early.
  logic hit1;
  logic hit2;

  assign hit1     = rf_we_q & (rf_waddr_q == rd_addr1) & (rd_addr1 != 5'd0);
  assign hit2     = rf_we_q & (rf_waddr_q == rd_addr2) & (rd_addr2 != 5'd0);
  assign rd_data1 = hit1 ? rf_wdata_q : rd_data1_in;
  assign rd_data2 = hit2 ? rf_wdata_q : rd_data2_in;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign rd_data1       = rd_data1_in;
  assign rd_data2       = rd_data2_in;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (MAX_WAIT = 4).
// Checks reset, A/B writes, r0 filtering, starvation, streak clearing, bypass.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1_in;
  logic [31:0] rd_data2_in;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  int n_run;
  int n_fail;

  regfile_write_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_reg(a_reg),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_reg(b_reg),
    .b_data(b_data),
    .b_ready(b_ready),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_data1_in(rd_data1_in),
    .rd_data2_in(rd_data2_in),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    a_valid     = 1'b1;
    a_reg       = 5'd3;
    a_data      = 32'h111;
    b_valid     = 1'b1;
    b_reg       = 5'd4;
    b_data      = 32'h222;
    rd_addr1    = 5'd0;
    rd_addr2    = 5'd0;
    rd_data1_in = 32'd0;
    rd_data2_in = 32'd0;

    // Reset with both requesters active
    step();
    step();
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_bready", {31'd0, b_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_bready", {31'd0, b_ready}, 32'd0);
    step();
    chk("rel_we", {31'd0, rf_we}, 32'd1);
    chk("rel_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("rel_wdata", rf_wdata, 32'h111);
    idle();
    chk("idle_we", {31'd0, rf_we}, 32'd0);
    chk("idle_hold", {27'd0, rf_waddr}, 32'd3);

    // A only
    a_valid = 1'b1;
    a_reg   = 5'd5;
    a_data  = 32'hDEADBEEF;
    step();
    chk("a_we", {31'd0, rf_we}, 32'd1);
    chk("a_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("a_wdata", rf_wdata, 32'hDEADBEEF);
    a_reg  = 5'd0;
    a_data = 32'h1;
    step();
    chk("a_r0_we", {31'd0, rf_we}, 32'd0);
    chk("a_r0_hold", rf_wdata, 32'hDEADBEEF);

    // B only
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_reg   = 5'd7;
    b_data  = 32'h12;
    #1;
    chk("b_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("b_we", {31'd0, rf_we}, 32'd1);
    chk("b_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("b_wdata", rf_wdata, 32'h12);
    b_reg  = 5'd0;
    b_data = 32'h99;
    #1;
    chk("b_r0_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("b_r0_we", {31'd0, rf_we}, 32'd0);
    idle();

    // Starvation: both held; stall in cycles 4 and 9
    a_valid = 1'b1;
    a_reg   = 5'd10;
    a_data  = 32'hA;
    b_valid = 1'b1;
    b_reg   = 5'd11;
    b_data  = 32'hB;
    for (int i = 0; i < 10; i++) begin
      logic st;
      st = (i == 4) || (i == 9);
      #1;
      chk($sformatf("stv_stall%0d", i), {31'd0, pipe_stall}, {31'd0, st});
      chk($sformatf("stv_ready%0d", i), {31'd0, b_ready}, {31'd0, st});
      step();
      chk($sformatf("stv_waddr%0d", i), {27'd0, rf_waddr},
          st ? 32'd11 : 32'd10);
    end
    chk("stv_back_run", {31'd0, pipe_stall}, 32'd0);
    idle();

    // B loses 3, then A drops: B granted, streak cleared
    a_valid = 1'b1;
    a_reg   = 5'd2;
    a_data  = 32'h20;
    b_valid = 1'b1;
    b_reg   = 5'd6;
    b_data  = 32'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("drop_nostall%0d", i), {31'd0, pipe_stall}, 32'd0);
    end
    a_valid = 1'b0;
    #1;
    chk("drop_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("drop_waddr", {27'd0, rf_waddr}, 32'd6);
    chk("drop_stall", {31'd0, pipe_stall}, 32'd0);
    a_valid = 1'b1;
    b_data  = 32'h61;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fresh_nostall%0d", i), {31'd0, pipe_stall}, 32'd0);
      step();
    end
    chk("fresh_stall", {31'd0, pipe_stall}, 32'd1);

    // Reset while in STARVE with a write pending
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("mid_rst_wdata", rf_wdata, 32'd0);
    chk("mid_rst_ready", {31'd0, b_ready}, 32'd0);
    step();
    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();

    // Bypass
    b_valid     = 1'b1;
    b_reg       = 5'd9;
    b_data      = 32'hCAFE;
    rd_addr1    = 5'd9;
    rd_data1_in = 32'd0;
    rd_addr2    = 5'd8;
    rd_data2_in = 32'h77;
    step();
    b_valid = 1'b0;
    #1;
    chk("byp_we", {31'd0, rf_we}, 32'd1);
`ifdef WB_BYPASS_EN
    chk("byp_rd1", rd_data1, 32'hCAFE);
`else
    chk("byp_rd1", rd_data1, 32'd0);
`endif
    chk("byp_rd2", rd_data2, 32'h77);
    a_valid     = 1'b1;
    a_reg       = 5'd0;
    a_data      = 32'h5;
    rd_addr1    = 5'd0;
    rd_data1_in = 32'h55;
    step();
    chk("byp_r0_rd1", rd_data1, 32'h55);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
